serial_adder_n: RTL

//  Parametrised, multi-cycle add/subtract unit with a start/done handshake.

---
 rtl/serial_adder_n.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle add/subtract unit.
// Each operation takes STEPS = WIDTH/DIGIT clocks. DIGIT bits are processed per
// clock through a carry flip-flop and shift registers. A start/done handshake
// frames each operation. Subtraction computes a + ~b + 1, so s[WIDTH] is the
// "no borrow" flag.
module serial_adder_n #(
  parameter int WIDTH = 2,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   s_q, s_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   digit_sum_s;
  logic             digit_cout_s;
  logic             msb_cin_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_step_s;

  // One digit of ripple addition, plus the shifted partial result
  always_comb begin
    digit_sum_s  = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
    digit_cout_s = digit_sum_s[DIGIT];
    // A sum bit is a ^ b ^ cin, so the carry into the digit's top bit is
    // recovered by undoing the XOR. On the last step this is the carry into
    // the word MSB.
    msb_cin_s    = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ digit_sum_s[DIGIT-1];
    res_next_s   = res_q >> DIGIT;
    res_next_s[WIDTH-1 -: DIGIT] = digit_sum_s[DIGIT-1:0];
    last_step_s  = (cnt_q == CW'(STEPS - 1));
  end

  // Next-state logic for the IDLE/RUN sequencer and its datapath registers
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{mode}};
          carry_d = mode;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        res_d   = res_next_s;
        carry_d = digit_cout_s;
        cnt_d   = cnt_q + CW'(1);
        if (last_step_s) begin
          s_d     = {digit_cout_s, res_next_s};
          ovf_d   = msb_cin_s ^ digit_cout_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign ovf  = ovf_q;

endmodule
